// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and
// redirect counter sizing.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int                   REDIR_CNT_W   = 8;
    localparam logic [REDIR_CNT_W-1:0] REDIR_CNT_MAX = 8'd255;

endpackage

// File: rtl/pc_sequencer_redirect_select.sv
// Combinational redirect resolution: raw taken/target for capture, and the
// selected redirect (pending first) with optional alignment check (PC_ALIGN_CHECK_EN).
module redirect_select
    import pc_seq_pkg::*;
#(
    parameter int DATA_W = 16
`ifdef PC_ALIGN_CHECK_EN
    , parameter int PC_INC = 4
`endif
) (
    input  logic              i_branch,
    input  logic              i_zero_flag,
    input  logic              i_jump,
    input  logic [DATA_W-1:0] i_branch_pc,
    input  logic [DATA_W-1:0] i_jump_pc,
    input  logic              i_pending_vld,
    input  logic [DATA_W-1:0] i_pending_pc,
    output logic              o_taken,
    output logic [DATA_W-1:0] o_target,
    output logic              o_sel_vld,
    output logic [DATA_W-1:0] o_sel_pc,
    output logic              o_sel_ok
);

    logic w_taken;
    logic [DATA_W-1:0] w_target;

    assign w_taken  = i_jump | (i_branch & i_zero_flag);
    assign w_target = i_jump ? i_jump_pc : i_branch_pc;

    assign o_taken  = w_taken;
    assign o_target = w_target;

    // A held redirect always beats whatever is being decoded this cycle.
    assign o_sel_vld = i_pending_vld | w_taken;
    assign o_sel_pc  = i_pending_vld ? i_pending_pc : w_target;

`ifdef PC_ALIGN_CHECK_EN
    assign o_sel_ok = ((o_sel_pc % DATA_W'(PC_INC)) == '0);
`else
    assign o_sel_ok = 1'b1;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer with stall-held redirect and multi-cycle
// IF/ID flush. Optional misalignment check under PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              DATA_W       = 16,
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter int              PC_INC       = 4,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_branch,
    input  logic              i_zero_flag,
    input  logic              i_jump,
    input  logic [DATA_W-1:0] i_branch_pc,
    input  logic [DATA_W-1:0] i_jump_pc,
    output logic [DATA_W-1:0] o_current_pc,
    output logic              o_pc_valid,
    output logic              o_flush,
    output logic [REDIR_CNT_W-1:0] o_redirect_cnt,
`ifdef PC_ALIGN_CHECK_EN
    output logic              o_misalign_err,
`endif
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t                 r_state;
    logic [DATA_W-1:0]      r_pc;
    logic                   r_pend_vld;
    logic [DATA_W-1:0]      r_pend_pc;
    logic [CNT_W-1:0]       r_cnt;
    logic [REDIR_CNT_W-1:0] r_redir_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic                   r_misalign;
`endif

    logic              w_taken;
    logic [DATA_W-1:0] w_target;
    logic              w_sel_vld;
    logic [DATA_W-1:0] w_sel_pc;
    logic              w_sel_ok;

    redirect_select #(
        .DATA_W (DATA_W)
`ifdef PC_ALIGN_CHECK_EN
        , .PC_INC (PC_INC)
`endif
    ) u_redirect_select (
        .i_branch      (i_branch),
        .i_zero_flag   (i_zero_flag),
        .i_jump        (i_jump),
        .i_branch_pc   (i_branch_pc),
        .i_jump_pc     (i_jump_pc),
        .i_pending_vld (r_pend_vld),
        .i_pending_pc  (r_pend_pc),
        .o_taken       (w_taken),
        .o_target      (w_target),
        .o_sel_vld     (w_sel_vld),
        .o_sel_pc      (w_sel_pc),
        .o_sel_ok      (w_sel_ok)
    );

    // i_enable=1 advances the pipeline one step this edge; i_enable=0 stalls and
    // nothing moves except capturing the first taken redirect seen in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= PC_RESET;
            r_pend_vld  <= 1'b0;
            r_pend_pc   <= '0;
            r_cnt       <= '0;
            r_redir_cnt <= '0;
`ifdef PC_ALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (i_enable) begin
                        r_pend_vld <= 1'b0;
                        if (w_sel_vld && w_sel_ok) begin
                            r_pc    <= w_sel_pc;
                            r_cnt   <= CNT_W'(FLUSH_CYCLES);
                            r_state <= ST_FLUSH;
                            if (r_redir_cnt != REDIR_CNT_MAX)
                                r_redir_cnt <= r_redir_cnt + REDIR_CNT_W'(1);
                        end else begin
                            r_pc <= r_pc + DATA_W'(PC_INC);
`ifdef PC_ALIGN_CHECK_EN
                            if (w_sel_vld)
                                r_misalign <= 1'b1;
`endif
                        end
                    end else if (w_taken && !r_pend_vld) begin
                        r_pend_vld <= 1'b1;
                        r_pend_pc  <= w_target;
                    end
                end
                ST_FLUSH: begin
                    if (i_enable) begin
                        r_pc  <= r_pc + DATA_W'(PC_INC);
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1))
                            r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign o_current_pc   = r_pc;
    assign o_pc_valid     = (r_state != ST_BOOT);
    assign o_flush        = (r_state == ST_FLUSH);
    assign o_redirect_cnt = r_redir_cnt;
    assign o_dbg_state    = r_state;
`ifdef PC_ALIGN_CHECK_EN
    assign o_misalign_err = r_misalign;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences and random
// stimulus against a behavioural model; two instances (PC_RESET 0 and 0xFFF8).
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int W    = 16;
    localparam int SB_W = W + 1 + 1 + 8 + 1;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, enable, branch, zero_flag, jump;
    logic [W-1:0] branch_pc, jump_pc;

    logic [W-1:0] pc0, pc1;
    logic         vld0, vld1, fl0, fl1;
    logic [7:0]   rc0, rc1;
    logic [1:0]   st0, st1;
    logic         mis0, mis1;
`ifndef PC_ALIGN_CHECK_EN
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
`endif

    pc_sequencer dut0 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_branch(branch),
        .i_zero_flag(zero_flag), .i_jump(jump), .i_branch_pc(branch_pc),
        .i_jump_pc(jump_pc), .o_current_pc(pc0), .o_pc_valid(vld0),
        .o_flush(fl0), .o_redirect_cnt(rc0),
`ifdef PC_ALIGN_CHECK_EN
        .o_misalign_err(mis0),
`endif
        .o_dbg_state(st0)
    );

    pc_sequencer #(.PC_RESET(16'hFFF8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_branch(branch),
        .i_zero_flag(zero_flag), .i_jump(jump), .i_branch_pc(branch_pc),
        .i_jump_pc(jump_pc), .o_current_pc(pc1), .o_pc_valid(vld1),
        .o_flush(fl1), .o_redirect_cnt(rc1),
`ifdef PC_ALIGN_CHECK_EN
        .o_misalign_err(mis1),
`endif
        .o_dbg_state(st1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_pc[2];
    bit           m_booted[2];
    int           m_flush_left[2];
    bit           m_pend_vld[2];
    logic [W-1:0] m_pend_pc[2];
    int           m_cnt[2];
    bit           m_mis[2];

    function automatic logic [W-1:0] reset_pc(input int k);
        return (k == 0) ? 16'h0000 : 16'hFFF8;
    endfunction

    task automatic model_apply(input int k, input logic [W-1:0] t);
        if (ALIGN_CHECK && (t % 4) != 0) begin
            m_pc[k]  = m_pc[k] + 16'd4;
            m_mis[k] = 1'b1;
        end else begin
            m_pc[k] = t;
            m_flush_left[k] = 2;
            if (m_cnt[k] < 255) m_cnt[k]++;
        end
    endtask

    task automatic model_step(input int k);
        bit           tk;
        logic [W-1:0] tg;
        tk = jump || (branch && zero_flag);
        tg = jump ? jump_pc : branch_pc;
        if (rst) begin
            m_pc[k] = reset_pc(k); m_booted[k] = 0; m_flush_left[k] = 0;
            m_pend_vld[k] = 0; m_cnt[k] = 0; m_mis[k] = 0;
        end else if (!m_booted[k]) begin
            m_booted[k] = 1;
        end else if (enable) begin
            if (m_flush_left[k] > 0) begin
                m_pc[k] = m_pc[k] + 16'd4;
                m_flush_left[k]--;
            end else if (m_pend_vld[k]) begin
                m_pend_vld[k] = 0;
                model_apply(k, m_pend_pc[k]);
            end else if (tk) begin
                model_apply(k, tg);
            end else begin
                m_pc[k] = m_pc[k] + 16'd4;
            end
        end else if (m_flush_left[k] == 0 && tk && !m_pend_vld[k]) begin
            m_pend_vld[k] = 1;
            m_pend_pc[k]  = tg;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    int cyc = 0;

    task automatic compare();
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        check("d0_pc", cyc, 32'(pc0), 32'(e[SB_W-1 -: W]));
        check("d0_vld", cyc, 32'(vld0), 32'(e[10]));
        check("d0_flush", cyc, 32'(fl0), 32'(e[9]));
        check("d0_rcnt", cyc, 32'(rc0), 32'(e[8:1]));
        if (ALIGN_CHECK) check("d0_mis", cyc, 32'(mis0), 32'(e[0]));
        e = exp_q.pop_front();
        check("d1_pc", cyc, 32'(pc1), 32'(e[SB_W-1 -: W]));
        check("d1_vld", cyc, 32'(vld1), 32'(e[10]));
        check("d1_flush", cyc, 32'(fl1), 32'(e[9]));
        check("d1_rcnt", cyc, 32'(rc1), 32'(e[8:1]));
        if (ALIGN_CHECK) check("d1_mis", cyc, 32'(mis1), 32'(e[0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic e, input logic b, input logic z,
                        input logic j, input logic [W-1:0] bp, input logic [W-1:0] jp);
        rst = r; enable = e; branch = b; zero_flag = z; jump = j;
        branch_pc = bp; jump_pc = jp;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            exp_q.push_back({m_pc[k], m_booted[k], (m_flush_left[k] > 0),
                             8'(m_cnt[k]), m_mis[k]});
        end
        #1;
        compare();
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         r, e, b, z, j;
        logic [W-1:0] bp, jp;
        logic [W-1:0] pc0, pc1;
        logic         vld, fl;
        logic [7:0]   cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, e, b, z, j, input logic [W-1:0] bp, jp,
                                input logic [W-1:0] p0, p1, input logic v, f,
                                input logic [7:0] c);
        vec_t x;
        x.r = r; x.e = e; x.b = b; x.z = z; x.j = j; x.bp = bp; x.jp = jp;
        x.pc0 = p0; x.pc1 = p1; x.vld = v; x.fl = f; x.cnt = c;
        return x;
    endfunction

    initial begin
        vecs[0]  = mk(1,0,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 0,0,0);
        vecs[1]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 1,0,0);
        vecs[2]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0004, 16'hFFFC, 1,0,0);
        vecs[3]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0008, 16'h0000, 1,0,0);
        vecs[4]  = mk(0,1,0,0,1, 16'h0,   16'h40,  16'h0040, 16'h0040, 1,1,1);
        vecs[5]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0044, 16'h0044, 1,1,1);
        vecs[6]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0048, 16'h0048, 1,0,1);
        vecs[7]  = mk(0,1,1,0,0, 16'h80,  16'h0,   16'h004C, 16'h004C, 1,0,1);
        vecs[8]  = mk(0,1,1,1,0, 16'h80,  16'h0,   16'h0080, 16'h0080, 1,1,2);
        vecs[9]  = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0084, 16'h0084, 1,1,2);
        vecs[10] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0088, 16'h0088, 1,0,2);
        vecs[11] = mk(0,1,1,1,1, 16'h200, 16'h100, 16'h0100, 16'h0100, 1,1,3);
        vecs[12] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0104, 16'h0104, 1,1,3);
        vecs[13] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0108, 16'h0108, 1,0,3);
        vecs[14] = mk(0,0,0,0,1, 16'h0,   16'h20,  16'h0108, 16'h0108, 1,0,3);
        vecs[15] = mk(0,0,1,1,0, 16'h30,  16'h0,   16'h0108, 16'h0108, 1,0,3);
        vecs[16] = mk(0,0,0,0,0, 16'h0,   16'h0,   16'h0108, 16'h0108, 1,0,3);
        vecs[17] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0020, 16'h0020, 1,1,4);
        vecs[18] = mk(0,0,0,0,0, 16'h0,   16'h0,   16'h0020, 16'h0020, 1,1,4);
        vecs[19] = mk(0,1,0,0,1, 16'h0,   16'h500, 16'h0024, 16'h0024, 1,1,4);
        vecs[20] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0028, 16'h0028, 1,0,4);
        vecs[21] = mk(0,1,0,0,1, 16'h0,   16'h60,  16'h0060, 16'h0060, 1,1,5);
        vecs[22] = mk(1,1,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 0,0,0);
        vecs[23] = mk(0,0,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 1,0,0);
        vecs[24] = mk(0,0,0,0,1, 16'h0,   16'h70,  16'h0000, 16'hFFF8, 1,0,0);
        vecs[25] = mk(1,0,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 0,0,0);
        vecs[26] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0000, 16'hFFF8, 1,0,0);
        vecs[27] = mk(0,1,0,0,0, 16'h0,   16'h0,   16'h0004, 16'hFFFC, 1,0,0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].b, vecs[i].z, vecs[i].j,
                 vecs[i].bp, vecs[i].jp);
            check("vec_pc0", i, 32'(pc0), 32'(vecs[i].pc0));
            check("vec_pc1", i, 32'(pc1), 32'(vecs[i].pc1));
            check("vec_vld", i, 32'(vld0), 32'(vecs[i].vld));
            check("vec_flush", i, 32'(fl0), 32'(vecs[i].fl));
            check("vec_rcnt", i, 32'(rc0), 32'(vecs[i].cnt));
        end

        // Saturation: a jump presented every cycle redirects once per 3 cycles.
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 800; i++) step(0, 1, 0, 0, 1, 16'h0, 16'h40);
        check("sat_rcnt0", 0, 32'(rc0), 32'd255);
        check("sat_rcnt1", 0, 32'(rc1), 32'd255);

        // Reset in the middle of a flush returns to BOOT.
        step(0, 1, 0, 0, 0, 16'h0, 16'h0);
        while (fl0 !== 1'b1 && cyc < 2000) step(0, 1, 0, 0, 1, 16'h0, 16'h90);
        check("mid_flush_pre", 0, 32'(fl0), 32'd1);
        step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        check("mid_flush_fl", 0, 32'(fl0), 32'd0);
        check("mid_flush_pc0", 0, 32'(pc0), 32'h0000);
        check("mid_flush_pc1", 0, 32'(pc1), 32'hFFF8);
        check("mid_flush_st", 0, 32'(st0), 32'd0);

`ifdef PC_ALIGN_CHECK_EN
        step(0, 1, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 0, 1, 16'h0, 16'h42);
        check("mis_pc", 0, 32'(pc0), 32'h0008);
        check("mis_fl", 0, 32'(fl0), 32'd0);
        check("mis_err", 0, 32'(mis0), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 16'h0, 16'h0);
        check("mis_sticky", 0, 32'(mis0), 32'd1);
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("mis_clear", 0, 32'(mis0), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] bp, jp;
            bp = 16'($urandom);
            jp = 16'($urandom);
            if ($urandom_range(0, 7) != 0) bp[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) jp[1:0] = 2'b00;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), bp, jp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the architectural PC register and sequences fetch. It consumes the branch/jump targets produced by the branch unit together with the decode control bits, and resolves taken redirects. It also holds a redirect that arrives during a pipeline stall and drives a multi-cycle flush to the IF/ID stages. It sits between decode/branch resolution and instruction-memory addressing.

## Interface
- DATA_W, 16, PC/target width
- PC_RESET, 0, PC value loaded at reset
- PC_INC, 4, sequential increment
- FLUSH_CYCLES, 2, number of enabled cycles flush stays high after a redirect (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  pipeline advance (0 = stall)
- branch  input  1  decode: conditional branch in flight
- zero_flag  input  1  ALU zero result for the branch
- jump  input  1  decode: unconditional jump in flight
- branch_pc  input  DATA_W  branch target from branch unit
- jump_pc  input  DATA_W  jump target from branch unit
- current_pc  output  DATA_W  PC presented to instruction memory
- pc_valid  output  1  current_pc is a real fetch address
- flush  output  1  squash IF/ID contents
- redirect_cnt  output  8  saturating count of applied redirects
- misalign_err  output  1  sticky; present only with PC_ALIGN_CHECK_EN

## Operation
- taken = jump | (branch & zero_flag); target = jump ? jump_pc : branch_pc (jump has priority).
- States: BOOT, RUN, FLUSH.
- BOOT: current_pc=PC_RESET, pc_valid=0; unconditionally → RUN next cycle (ignores enable and taken).
- RUN, enable=1, pending_vld=1: pc←pending_pc, clear pending, cnt←FLUSH_CYCLES, → FLUSH. The pending redirect wins over a simultaneous taken.
- RUN, enable=1, no pending, taken: pc←target, cnt←FLUSH_CYCLES, → FLUSH.
- RUN, enable=1, not taken: pc←pc+PC_INC.
- RUN, enable=0, taken, no pending: pending_vld←1, pending_pc←target; pc holds. If a redirect is already pending, later taken requests are ignored (first wins).
- FLUSH, enable=1: pc←pc+PC_INC, cnt←cnt−1; cnt==1 → RUN. Taken inputs are ignored.
- FLUSH, enable=0: everything holds.
- flush = (state==FLUSH); pc_valid = (state!=BOOT).
- redirect_cnt increments by 1 on each applied redirect (the pc load, not the capture into pending) and saturates at 255.
- Arithmetic is unsigned modulo 2^DATA_W; pc+PC_INC wraps silently (0xFFFC+4 → 0x0000 at DATA_W=16).

## Timing
- Reset values: current_pc=PC_RESET, pc_valid=0, flush=0, redirect_cnt=0, misalign_err=0, pending_vld=0, state=BOOT.
- rst is sampled at the edge and overrides everything. Asserting it in any state (including FLUSH or with a pending redirect) returns to BOOT and discards the pending target and cnt.
- Redirect latency: taken sampled at edge N (enable=1) → current_pc=target and flush=1 during cycle N+1. flush stays high for FLUSH_CYCLES enabled cycles.
- Pending redirect: applied at the first edge with enable=1; current_pc shows the target the cycle after.
- All outputs are registered or decoded from registered state; there is no combinational input→output path.

## Configuration
- PC_ALIGN_CHECK_EN defined: a target with (target mod PC_INC)≠0 is not applied (pc advances as not-taken, no flush, no count) and sets misalign_err sticky until rst. The same check is applied to pending_pc when it is applied.
- Undefined: no check; the misalign_err port is absent; every target is applied as-is.

## Structure
- Package pc_seq_pkg: state encoding (BOOT=2'd0, RUN=2'd1, FLUSH=2'd2) and the redirect counter width/saturation constant (8, 255).
- Sub-module redirect_select: combinational taken/target resolution, plus the alignment check under the macro. The FSM, PC register, pending buffer and counter live in pc_sequencer.

## Test plan
- Reset then enable=1, no control: current_pc goes 0 (pc_valid=0), 0, 4, 8, 12; flush stays 0.
- At pc=8: jump=1, jump_pc=0x40 → next cycle current_pc=0x40, flush=1 for 2 cycles, then 0x44, 0x48; redirect_cnt=1.
- branch=1, zero_flag=0, branch_pc=0x80 → no redirect, pc+4. With zero_flag=1 → current_pc=0x80. With jump=1 and branch=1 both asserted → jump_pc is used.
- enable=0 with jump_pc=0x20, next stall cycle branch_pc=0x30 taken; enable=1 after 3 cycles → current_pc=0x20, flush asserted.
- PC_RESET=0xFFF8: sequence runs 0xFFF8, 0xFFFC, 0x0000. 256+ redirects → redirect_cnt holds at 255. rst mid-FLUSH → BOOT, flush=0, current_pc=PC_RESET.
- PC_ALIGN_CHECK_EN, jump_pc=0x42 → pc advances by 4, flush=0, misalign_err=1 and it persists until rst.
